// File: rtl/mxpl_writer.sv
// -----------------------------------------------------------------------------
// mxpl_writer
//
// Output-side writer for the max-pooling stage. Each pooled value strobed by
// the max-pool unit (mxplDone) is optionally ReLU-clamped, queued in a 4-entry
// FIFO and written to the output feature-map SRAM through a single-register
// output stage. Addresses are a dense row-major raster starting at baseAddr,
// which is latched on start. A one-cycle frameDone pulse follows the
// acceptance of the last write of the OUT_W x OUT_H frame.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   reset      asynchronous, active-high reset
//   start      one-cycle pulse, begins a frame and latches baseAddr (IDLE only)
//   baseAddr   address of pooled pixel (0,0)
//   result     pooled value (signed two's complement)
//   mxplDone   result valid strobe
//   memReady   SRAM accepts the presented write this cycle
//   memWe      write request
//   memAddr    write address
//   memData    write data
//   busy       high from start until the end of the frameDone cycle
//   frameDone  one-cycle pulse after the last write is accepted
//   overflow   sticky, a result was dropped because the buffer was full
// -----------------------------------------------------------------------------
module mxpl_writer #(
  parameter int DATAW = 20,
  parameter int ADDRW = 12,
  parameter int OUT_W = 14,
  parameter int OUT_H = 14,
  parameter int RELU  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [ADDRW-1:0] baseAddr,
  input  logic [DATAW-1:0] result,
  input  logic             mxplDone,
  input  logic             memReady,
  output logic             memWe,
  output logic [ADDRW-1:0] memAddr,
  output logic [DATAW-1:0] memData,
  output logic             busy,
  output logic             frameDone,
  output logic             overflow
);

  localparam int NPIX       = OUT_W * OUT_H;
  localparam int CNTW       = $clog2(NPIX + 1);
  localparam int FIFO_DEPTH = 4;
  localparam int PTRW       = 2;

  localparam logic [CNTW-1:0] NPIX_C = CNTW'(NPIX);
  localparam logic [CNTW-1:0] LAST_C = CNTW'(NPIX - 1);
  localparam logic [2:0]      FULL_C = 3'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;
  logic   frame_start;

  // FIFO
  logic [DATAW-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTRW-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [2:0]       fifo_cnt_reg;

  // Output stage; addr_reg doubles as the raster address counter
  logic             we_reg;
  logic [ADDRW-1:0] addr_reg;
  logic [DATAW-1:0] data_reg;

  // Frame bookkeeping
  logic [CNTW-1:0]  wr_cnt_reg;    // accepted writes
  logic [CNTW-1:0]  push_cnt_reg;  // values stored into the FIFO
  logic             overflow_reg;

  logic             in_run;
  logic             accept;
  logic             push_req;
  logic             push;
  logic             pop;
  logic             drop;
  logic             fifo_full;
  logic             last_write;
  logic [DATAW-1:0] push_data;
  logic [DATAW-1:0] fifo_head;

  // ---------------------------------------------------------------------------
  // Datapath control
  // ---------------------------------------------------------------------------
  assign in_run    = (state_reg == RUN);
  assign accept    = we_reg && memReady;
  assign fifo_full = (fifo_cnt_reg == FULL_C);
  assign fifo_head = fifo_mem[rd_ptr_reg];

  // Once the whole frame has been captured, later strobes are simply ignored:
  // they are neither stored nor counted as overflow.
  assign push_req  = in_run && mxplDone && (push_cnt_reg != NPIX_C);

  // The output stage refills whenever it is empty or its write retires now.
  assign pop       = in_run && (fifo_cnt_reg != 3'd0) && (!we_reg || memReady);

  // A full FIFO can still take a value when its head leaves in the same cycle.
  assign push      = push_req && (!fifo_full || pop);
  assign drop      = push_req && fifo_full && !pop;

  assign last_write = in_run && accept && (wr_cnt_reg == LAST_C);

  // ReLU: a set sign bit means negative in two's complement.
  assign push_data = ((RELU != 0) && result[DATAW-1]) ? '0 : result;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    frame_start = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next  = RUN;
          frame_start = 1'b1;
        end
      end
      RUN: begin
        if (last_write) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO storage (contents need no reset; validity lives in the counters)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= push_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers, counters, output stage and overflow flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      data_reg     <= '0;
      wr_cnt_reg   <= '0;
      push_cnt_reg <= '0;
      overflow_reg <= 1'b0;
    end else if (frame_start) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
      we_reg       <= 1'b0;
      addr_reg     <= baseAddr;
      data_reg     <= '0;
      wr_cnt_reg   <= '0;
      push_cnt_reg <= '0;
      overflow_reg <= 1'b0;
    end else begin
      // Output stage: refill takes priority over retiring the current write.
      if (pop) begin
        we_reg   <= 1'b1;
        data_reg <= fifo_head;
      end else if (accept) begin
        we_reg   <= 1'b0;
      end

      // The address advances only on acceptance, so it holds during a stall
      // and always names the write currently (or next) presented.
      if (accept) begin
        addr_reg   <= addr_reg + ADDRW'(1);
        wr_cnt_reg <= wr_cnt_reg + CNTW'(1);
      end

      if (push) begin
        wr_ptr_reg   <= wr_ptr_reg + PTRW'(1);
        push_cnt_reg <= push_cnt_reg + CNTW'(1);
      end

      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTRW'(1);
      end

      fifo_cnt_reg <= fifo_cnt_reg + {2'b00, push} - {2'b00, pop};

      if (drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign memWe     = we_reg;
  assign memAddr   = addr_reg;
  assign memData   = data_reg;
  assign busy      = (state_reg != IDLE);
  assign frameDone = (state_reg == DONE);
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_mxpl_writer.sv
// -----------------------------------------------------------------------------
// tb_mxpl_writer
//
// Two instances share every input: one with RELU=1, one with RELU=0, both on a
// 3x2 pooled map. A behavioural model tracks the frame as a queue of stored
// values with their capture cycles; a value becomes visible on the write port
// two cycles after capture or one cycle after the previous write retires,
// whichever is later. Directed scenarios are followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_mxpl_writer;

  localparam int DATAW = 20;
  localparam int ADDRW = 12;
  localparam int OUT_W = 3;
  localparam int OUT_H = 2;
  localparam int NPIX  = OUT_W * OUT_H;
  localparam int BUFN  = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [ADDRW-1:0] baseAddr;
  logic [DATAW-1:0] result;
  logic             mxplDone;
  logic             memReady;

  logic             r_memWe, n_memWe;
  logic [ADDRW-1:0] r_memAddr, n_memAddr;
  logic [DATAW-1:0] r_memData, n_memData;
  logic             r_busy, n_busy;
  logic             r_frameDone, n_frameDone;
  logic             r_overflow, n_overflow;

  mxpl_writer #(.DATAW(DATAW), .ADDRW(ADDRW), .OUT_W(OUT_W), .OUT_H(OUT_H), .RELU(1)) dut_relu (
    .clk(clk), .reset(reset), .start(start), .baseAddr(baseAddr), .result(result),
    .mxplDone(mxplDone), .memReady(memReady), .memWe(r_memWe), .memAddr(r_memAddr),
    .memData(r_memData), .busy(r_busy), .frameDone(r_frameDone), .overflow(r_overflow)
  );

  mxpl_writer #(.DATAW(DATAW), .ADDRW(ADDRW), .OUT_W(OUT_W), .OUT_H(OUT_H), .RELU(0)) dut_raw (
    .clk(clk), .reset(reset), .start(start), .baseAddr(baseAddr), .result(result),
    .mxplDone(mxplDone), .memReady(memReady), .memWe(n_memWe), .memAddr(n_memAddr),
    .memData(n_memData), .busy(n_busy), .frameDone(n_frameDone), .overflow(n_overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  bit               m_active;
  int               m_done_cyc;
  logic [ADDRW-1:0] m_base;
  int               m_acc;
  int               m_stored;
  int               m_last_acc;
  bit               m_ovf;
  logic [DATAW-1:0] q_data[$];
  int               q_pc[$];

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DATAW-1:0] relu_f(input logic [DATAW-1:0] x);
    return ($signed(x) < 0) ? '0 : x;
  endfunction

  function automatic bit model_we();
    int vis;
    if (!m_active || q_data.size() == 0) return 1'b0;
    vis = q_pc[0] + 2;
    if (m_last_acc + 1 > vis) vis = m_last_acc + 1;
    return (cyc >= vis);
  endfunction

  task automatic model_reset();
    m_active   = 1'b0;
    m_done_cyc = -10;
    m_base     = '0;
    m_acc      = 0;
    m_stored   = 0;
    m_last_acc = 0;
    m_ovf      = 1'b0;
    q_data.delete();
    q_pc.delete();
  endtask

  // One clock cycle: check outputs, drive inputs, advance the model.
  task automatic step(input bit st, input logic [ADDRW-1:0] ba, input logic [DATAW-1:0] res,
                      input bit md, input bit rdy);
    bit               we_e;
    bit               acc;
    bit               done_e;
    logic [ADDRW-1:0] addr_e;
    @(negedge clk);
    we_e   = model_we();
    done_e = (cyc == m_done_cyc);
    chk("relu.memWe", r_memWe, we_e);
    chk("raw.memWe", n_memWe, we_e);
    chk("relu.busy", r_busy, m_active || done_e);
    chk("raw.busy", n_busy, m_active || done_e);
    chk("relu.frameDone", r_frameDone, done_e);
    chk("raw.frameDone", n_frameDone, done_e);
    chk("relu.overflow", r_overflow, m_ovf);
    chk("raw.overflow", n_overflow, m_ovf);
    if (we_e) begin
      addr_e = m_base + ADDRW'(m_acc);
      chk("relu.memAddr", r_memAddr, addr_e);
      chk("raw.memAddr", n_memAddr, addr_e);
      chk("relu.memData", r_memData, relu_f(q_data[0]));
      chk("raw.memData", n_memData, q_data[0]);
    end

    start    = st;
    baseAddr = ba;
    result   = res;
    mxplDone = md;
    memReady = rdy;

    acc = we_e && rdy;
    if (done_e) begin
      // frame finished; back to idle, inputs ignored
    end else if (!m_active) begin
      if (st) begin
        m_active   = 1'b1;
        m_base     = ba;
        m_acc      = 0;
        m_stored   = 0;
        m_last_acc = cyc;
        m_ovf      = 1'b0;
        q_data.delete();
        q_pc.delete();
      end
    end else begin
      if (md && m_stored < NPIX) begin
        if (q_data.size() == BUFN && !acc) begin
          m_ovf = 1'b1;
        end else begin
          q_data.push_back(res);
          q_pc.push_back(cyc);
          m_stored++;
        end
      end
      if (acc) begin
        void'(q_data.pop_front());
        void'(q_pc.pop_front());
        m_acc++;
        m_last_acc = cyc;
        if (m_acc == NPIX) begin
          m_active   = 1'b0;
          m_done_cyc = cyc + 1;
        end
      end
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, rdy);
  endtask

  // Asserts reset between clock edges and checks outputs before any edge.
  task automatic async_reset();
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("arst.memWe", r_memWe, 0);
    chk("arst.busy", r_busy, 0);
    chk("arst.overflow", r_overflow, 0);
    chk("arst.memAddr", r_memAddr, 0);
    chk("arst.raw.memWe", n_memWe, 0);
    chk("arst.raw.busy", n_busy, 0);
    model_reset();
    start    = 1'b0;
    mxplDone = 1'b0;
    memReady = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [DATAW-1:0] vals [6];
    logic [ADDRW-1:0] ba;
    int               p_md;
    int               p_rdy;

    model_reset();
    reset    = 1'b1;
    start    = 1'b0;
    baseAddr = '0;
    result   = '0;
    mxplDone = 1'b0;
    memReady = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.memWe", r_memWe, 0);
    chk("rst.memAddr", r_memAddr, 0);
    chk("rst.memData", r_memData, 0);
    chk("rst.busy", r_busy, 0);
    chk("rst.frameDone", r_frameDone, 0);
    chk("rst.overflow", r_overflow, 0);
    reset = 1'b0;

    // Strobes in IDLE are ignored
    for (int i = 0; i < 4; i++) step(1'b0, 12'h0AA, DATAW'(-7), 1'b1, 1'b1);
    idle(3, 1'b1);

    // Basic frame with mixed signs; extra start pulses mid-frame are ignored
    vals[0] = DATAW'(5);  vals[1] = DATAW'(-3); vals[2] = DATAW'(7);
    vals[3] = DATAW'(0);  vals[4] = DATAW'(9);  vals[5] = DATAW'(-1);
    step(1'b1, 12'h100, '0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(i == 2, 12'h555, vals[i], 1'b1, 1'b1);
    idle(6, 1'b1);

    // Backpressure: 6 strobes during a stall, sixth is dropped
    step(1'b1, 12'h200, '0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, '0, DATAW'(i * 3 - 8), 1'b1, 1'b0);
    idle(3, 1'b0);
    idle(3, 1'b1);
    step(1'b0, '0, DATAW'(-100), 1'b1, 1'b1);
    idle(6, 1'b1);

    // Address wrap at the top of the space
    step(1'b1, 12'hFFF, '0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, '0, DATAW'($urandom), 1'b1, 1'b1);
    idle(6, 1'b1);

    // Async reset during a stalled write with overflow set
    step(1'b1, 12'h321, '0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, '0, DATAW'(i + 1), 1'b1, 1'b0);
    chk("pre_arst.memWe", r_memWe, 1);
    chk("pre_arst.overflow", r_overflow, 1);
    async_reset();

    // Clean frame after reset
    step(1'b1, 12'h040, '0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, '0, DATAW'(-(i + 1)), 1'b1, 1'b1);
    idle(6, 1'b1);

    // Randomized traffic
    for (int blk = 0; blk < 40; blk++) begin
      p_md  = $urandom_range(30, 100);
      p_rdy = $urandom_range(20, 100);
      for (int i = 0; i < 80; i++) begin
        ba = ($urandom_range(0, 3) == 0) ? ADDRW'(12'hFFC + $urandom_range(0, 3))
                                         : ADDRW'($urandom);
        step($urandom_range(0, 19) == 0, ba, DATAW'($urandom),
             $urandom_range(1, 100) <= p_md, $urandom_range(1, 100) <= p_rdy);
      end
    end
    idle(20, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
